// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - mips_16 instruction fetch front end with 2-entry prefetch FIFO
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instruction_fetch_en,
    input  logic        branch_taken,
    input  logic [5:0]  branch_offset_imm,
    output logic [15:0] instruction,
    output logic [15:0] current_pc,
    output logic        fetch_stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata
);

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [15:0] fifo_instr [2];
    logic [15:0] fifo_pc    [2];
    logic [1:0]  count;
    logic [15:0] fetch_pc;
    logic [15:0] id_pc;
    logic [15:0] drain_addr;
    logic        redirect;
    logic        pop;
    logic        push;
    logic [15:0] target;

    assign redirect = branch_taken & instruction_fetch_en;
    assign target   = id_pc + 16'd1 + {{10{branch_offset_imm[5]}}, branch_offset_imm};
    assign pop      = instruction_fetch_en & (count != 2'd0) & ~redirect;
    assign push     = (state == FETCH) & imem_req & imem_ack & ~redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // An outstanding request cannot be withdrawn, so a redirect mid-request parks in DRAIN
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (redirect && imem_req && !imem_ack) state_nxt = DRAIN;
            DRAIN: if (imem_ack) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        instruction = NOP_INSTR;
        if (count != 2'd0 && !redirect) instruction = fifo_instr[0];
        current_pc  = (count != 2'd0) ? fifo_pc[0] : fetch_pc;
        fetch_stall = (count == 2'd0);
        imem_req    = rst_n & (((state == FETCH) & (count != 2'd2)) | (state == DRAIN));
        imem_addr   = (state == FETCH) ? fetch_pc : drain_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            fetch_pc   <= RESET_PC;
            id_pc      <= 16'h0000;
            drain_addr <= 16'h0000;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 16'h0000;
                fifo_pc[i]    <= 16'h0000;
            end
        end else begin
            if (pop) id_pc <= fifo_pc[0];

            if (redirect) fetch_pc <= target;
            else if (push) fetch_pc <= fetch_pc + 16'd1;

            if (state == FETCH && redirect && imem_req && !imem_ack) drain_addr <= fetch_pc;

            if (redirect) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        fifo_instr[count[0]] <= imem_rdata;
                        fifo_pc[count[0]]    <= fetch_pc;
                        count                <= count + 2'd1;
                    end
                    2'b01: begin
                        fifo_instr[0] <= fifo_instr[1];
                        fifo_pc[0]    <= fifo_pc[1];
                        count         <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd2) begin
                            fifo_instr[0] <= fifo_instr[1];
                            fifo_pc[0]    <= fifo_pc[1];
                            fifo_instr[1] <= imem_rdata;
                            fifo_pc[1]    <= fetch_pc;
                        end else begin
                            fifo_instr[0] <= imem_rdata;
                            fifo_pc[0]    <= fetch_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fe = 1'b0;
    logic        br = 1'b0;
    logic [5:0]  imm = 6'd0;
    logic [15:0] instruction, current_pc, imem_addr, imem_rdata;
    logic        fetch_stall, imem_req, imem_ack;

    int          checks = 0;
    int          failures = 0;

    logic        rand_mode = 1'b0;
    int          lat_fixed = 0;
    int          lat_rand = 0;
    int          lat;
    int          wcnt;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .instruction_fetch_en(fe), .branch_taken(br), .branch_offset_imm(imm),
        .instruction(instruction), .current_pc(current_pc), .fetch_stall(fetch_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 | a;
    endfunction

    // Memory: acks after `lat` waiting cycles, zero-wait when lat==0
    assign lat        = rand_mode ? lat_rand : lat_fixed;
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (imem_ack) lat_rand <= int'($urandom_range(0, 3));
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        fe = 1'b0;
        br = 1'b0;
        imm = 6'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        fe;
        logic        br;
        logic [5:0]  imm;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        stall;
        logic        req;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs [14];

    logic [15:0] exp_pc, id_pc_m, prev_addr;
    logic        id_valid, prev_pending;
    int          consumed;
    int          n;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 6'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 6'h00, 16'h1000, 16'h0000, 1'b0, 1'b1, 16'h0001};
        vecs[2]  = '{1'b1, 1'b0, 6'h00, 16'h1001, 16'h0001, 1'b0, 1'b1, 16'h0002};
        vecs[3]  = '{1'b1, 1'b0, 6'h00, 16'h1002, 16'h0002, 1'b0, 1'b1, 16'h0003};
        vecs[4]  = '{1'b0, 1'b0, 6'h00, 16'h1003, 16'h0003, 1'b0, 1'b1, 16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 6'h00, 16'h1003, 16'h0003, 1'b0, 1'b0, 16'h0005};
        vecs[6]  = '{1'b0, 1'b0, 6'h00, 16'h1003, 16'h0003, 1'b0, 1'b0, 16'h0005};
        vecs[7]  = '{1'b0, 1'b0, 6'h00, 16'h1003, 16'h0003, 1'b0, 1'b0, 16'h0005};
        vecs[8]  = '{1'b1, 1'b0, 6'h00, 16'h1003, 16'h0003, 1'b0, 1'b0, 16'h0005};
        vecs[9]  = '{1'b1, 1'b0, 6'h00, 16'h1004, 16'h0004, 1'b0, 1'b1, 16'h0005};
        vecs[10] = '{1'b1, 1'b0, 6'h00, 16'h1005, 16'h0005, 1'b0, 1'b1, 16'h0006};
        vecs[11] = '{1'b1, 1'b1, 6'h3E, 16'h0000, 16'h0006, 1'b0, 1'b1, 16'h0007};
        vecs[12] = '{1'b1, 1'b0, 6'h00, 16'h0000, 16'h0004, 1'b1, 1'b1, 16'h0004};
        vecs[13] = '{1'b1, 1'b0, 6'h00, 16'h1004, 16'h0004, 1'b0, 1'b1, 16'h0005};

        // Reset state
        #1;
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_stall", {15'd0, fetch_stall}, 16'd1);
        chk("rst_pc", current_pc, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'd0);

        // Zero-wait streaming, decode stall/resume, backward branch
        lat_fixed = 0;
        reset_dut();
        for (int i = 0; i < 14; i++) begin
            fe = vecs[i].fe;
            br = vecs[i].br;
            imm = vecs[i].imm;
            #1;
            chk($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
            chk($sformatf("vec%0d_pc", i), current_pc, vecs[i].pc);
            chk($sformatf("vec%0d_stall", i), {15'd0, fetch_stall}, {15'd0, vecs[i].stall});
            chk($sformatf("vec%0d_req", i), {15'd0, imem_req}, {15'd0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            @(negedge clk);
        end
        br = 1'b0;

        // Two-cycle memory wait: bubbles with a stable address
        lat_fixed = 2;
        reset_dut();
        fe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wait%0d_instr", k), instruction, 16'h0000);
            chk($sformatf("wait%0d_stall", k), {15'd0, fetch_stall}, 16'd1);
            chk($sformatf("wait%0d_addr", k), imem_addr, 16'h0000);
            @(negedge clk);
        end
        #1;
        chk("wait_first_instr", instruction, 16'h1000);
        @(negedge clk);

        // Redirect while the request to addr 8 is outstanding
        lat_fixed = 0;
        reset_dut();
        fe = 1'b1;
        for (int k = 0; k < 8; k++) @(negedge clk);
        lat_fixed = 3;
        #1;
        chk("drain_pre_instr", instruction, 16'h1007);
        chk("drain_pre_addr", imem_addr, 16'h0008);
        @(negedge clk);
        br = 1'b1;
        imm = 6'h04;
        #1;
        chk("drain_redir_instr", instruction, 16'h0000);
        chk("drain_redir_addr", imem_addr, 16'h0008);
        @(negedge clk);
        br = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drain%0d_req", k), {15'd0, imem_req}, 16'd1);
            chk($sformatf("drain%0d_addr", k), imem_addr, 16'h0008);
            chk($sformatf("drain%0d_instr", k), instruction, 16'h0000);
            @(negedge clk);
        end
        #1;
        chk("drain_target_addr", imem_addr, 16'h000C);
        chk("drain_target_req", {15'd0, imem_req}, 16'd1);
        for (n = 0; n < 20 && fetch_stall; n++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", {15'd0, (n < 20)}, 16'd1);
        chk("drain_target_instr", instruction, 16'h100C);
        chk("drain_target_pc", current_pc, 16'h000C);
        @(negedge clk);

        // Asynchronous reset in the middle of a memory wait
        lat_fixed = 3;
        reset_dut();
        fe = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {15'd0, imem_req}, 16'd0);
        chk("midrst_instr", instruction, 16'h0000);
        chk("midrst_stall", {15'd0, fetch_stall}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_addr", imem_addr, 16'h0000);
        chk("midrst_req_after", {15'd0, imem_req}, 16'd1);
        @(negedge clk);

        // Branch targets wrapping below 0 and above 16'hFFFF
        lat_fixed = 0;
        reset_dut();
        fe = 1'b1;
        @(negedge clk);
        #1;
        chk("wrap_c1_pc", current_pc, 16'h0000);
        @(negedge clk);
        br = 1'b1;
        imm = 6'h3D;
        #1;
        chk("wrap_c2_instr", instruction, 16'h0000);
        @(negedge clk);
        br = 1'b0;
        #1;
        chk("wrap_c3_addr", imem_addr, 16'hFFFE);
        @(negedge clk);
        #1;
        chk("wrap_c4_instr", instruction, 16'hFFFE);
        chk("wrap_c4_pc", current_pc, 16'hFFFE);
        @(negedge clk);
        br = 1'b1;
        imm = 6'h03;
        #1;
        chk("wrap_c5_instr", instruction, 16'h0000);
        @(negedge clk);
        br = 1'b0;
        #1;
        chk("wrap_c6_addr", imem_addr, 16'h0002);
        @(negedge clk);
        #1;
        chk("wrap_c7_instr", instruction, 16'h1002);
        chk("wrap_c7_pc", current_pc, 16'h0002);
        @(negedge clk);

        // Random traffic against a program-order reference model
        rand_mode = 1'b1;
        reset_dut();
        exp_pc = 16'h0000;
        id_pc_m = 16'h0000;
        id_valid = 1'b0;
        prev_pending = 1'b0;
        prev_addr = 16'h0000;
        consumed = 0;
        for (int c = 0; c < 2000; c++) begin
            fe = ($urandom_range(0, 3) != 0);
            br = id_valid && ($urandom_range(0, 9) == 0);
            imm = 6'($urandom);
            #1;
            if (prev_pending) begin
                chk("rnd_req_hold", {15'd0, imem_req}, 16'd1);
                chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (fe && br) begin
                chk("rnd_squash", instruction, 16'h0000);
                exp_pc = id_pc_m + 16'd1 + {{10{imm[5]}}, imm};
            end else if (fetch_stall) begin
                chk("rnd_bubble", instruction, 16'h0000);
            end else if (fe) begin
                chk("rnd_pc", current_pc, exp_pc);
                chk("rnd_instr", instruction, mem_word(exp_pc));
                id_pc_m = exp_pc;
                id_valid = 1'b1;
                exp_pc = exp_pc + 16'd1;
                consumed++;
            end
            @(negedge clk);
        end
        chk("rnd_progress", {15'd0, (consumed > 200)}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
